mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates one single-port synchronous SRAM between the core's instruction-fetch requester (IF1) and its data requester (MEM). Each cycle it grants at most one requester and drives the SRAM port. It routes the read data, which returns one cycle later, back to the granted requester. A losing requester sees no grant and must hold its request; the pipeline uses this as a stall.

Parameters:
DATA_WIDTH, 32, width of read/write data
ADDR_WIDTH, 12, word address width of the shared SRAM
STARVE_LIMIT, 4, consecutive denied instruction-request cycles before instruction gets forced priority (range 1..15)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_inst_req  input  1  instruction read request
i_inst_addr  input  ADDR_WIDTH  instruction word address
o_inst_gnt  output  1  instruction request accepted this cycle
o_inst_rvalid  output  1  instruction read data valid
o_inst_rdata  output  DATA_WIDTH  instruction read data
i_data_req  input  1  data request
i_data_we  input  1  1 = write, 0 = read
i_data_addr  input  ADDR_WIDTH  data word address
i_data_wdata  input  DATA_WIDTH  write data
o_data_gnt  output  1  data request accepted this cycle
o_data_rvalid  output  1  data read data valid (reads only)
o_data_rdata  output  DATA_WIDTH  data read data
o_mem_en  output  1  SRAM enable
o_mem_we  output  1  SRAM write enable
o_mem_addr  output  ADDR_WIDTH  SRAM address
o_mem_wdata  output  DATA_WIDTH  SRAM write data
i_mem_rdata  input  DATA_WIDTH  SRAM read data, valid one cycle after an enabled read

Behaviour:
- Grant decision is combinational in the same cycle; requests may change every cycle. A grant means the access is issued this cycle.
- Priority:
  - Only one request present: that request is granted.
  - Both present: data wins, unless starve_cnt >= STARVE_LIMIT, in which case instruction wins.
  - o_inst_gnt and o_data_gnt are never both 1.
- starve_cnt (4-bit register):
  - Increments when i_inst_req=1 and o_inst_gnt=0, saturating at 15.
  - Clears when o_inst_gnt=1.
  - Holds when i_inst_req=0.
- SRAM port:
  - o_mem_en is the OR of the two grants.
  - o_mem_we = o_data_gnt & i_data_we.
  - o_mem_addr and o_mem_wdata are muxed from the granted requester.
  - When idle, o_mem_addr=0 and o_mem_wdata=0.
- Response tag: owner register with values NONE, INST, DATA.
  - Set to INST on an instruction grant.
  - Set to DATA on a data read grant.
  - Set to NONE on a data write grant or when idle.
- Read latency is exactly 1 cycle after the grant:
  - o_inst_rvalid = (owner==INST).
  - o_data_rvalid = (owner==DATA).
  - Both rdata outputs carry i_mem_rdata when their rvalid is 1, else 0.
- Writes complete on grant and produce no rvalid.
- Back-to-back grants are allowed every cycle. A new grant in cycle N+1 does not disturb the response for the grant in cycle N.
- Reset values: owner=NONE, starve_cnt=0, so every rvalid=0 and every rdata=0. Grant and mem outputs follow their combinational equations; with no requests, all are 0.
- Reset asserted mid-operation: an outstanding response is discarded and no rvalid is produced after reset releases.
- Simultaneous data write and instruction request at the starvation limit: instruction is granted, the write is not performed, and the data side must hold its request.

Optional Feature:
Macro MEM_ARB_PERF_CNT_EN.
- Defined: adds two outputs, o_inst_stall_cnt[31:0] and o_conflict_cnt[31:0]. Both are registers, reset to 0 and saturating at 0xFFFFFFFF.
  - o_inst_stall_cnt increments on every cycle with i_inst_req & ~o_inst_gnt.
  - o_conflict_cnt increments on every cycle with i_inst_req & i_data_req.
- Not defined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset, no requests -> all outputs 0; starve_cnt=0.
- Instruction-only read of addr 0x010, SRAM word there = 0x00500093 -> o_inst_gnt=1 in cycle N; o_inst_rvalid=1 and o_inst_rdata=0x00500093 in N+1; o_data_rvalid stays 0.
- Both request every cycle, data reads, STARVE_LIMIT=4 -> data granted cycles 0-3, instruction granted cycle 4, data cycles 5-8, instruction cycle 9. The pattern repeats, and no cycle has two grants.
- Data write 0xDEADBEEF to 0x020 followed by a data read of 0x020 -> o_mem_we=1 only in the write cycle; read returns 0xDEADBEEF with o_data_rvalid one cycle after its grant; the write produces no rvalid.
- Alternating instruction grant (cycle N) and data read grant (cycle N+1) -> o_inst_rvalid in N+1 and o_data_rvalid in N+2, each carrying the correct word.
- Reset pulsed in the cycle after an instruction grant -> no o_inst_rvalid after release; with MEM_ARB_PERF_CNT_EN, 3 conflict cycles give o_conflict_cnt=3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request, grant, response and SRAM-port signals of the
// shared instruction/data memory arbiter.
//   slave  : arbiter side (takes requests and SRAM read data; drives grants,
//            responses and the SRAM port)
//   master : requester/SRAM side (the opposite directions)
interface mem_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12
);
   // instruction requester
   logic                  i_inst_req;
   logic [ADDR_WIDTH-1:0] i_inst_addr;
   logic                  o_inst_gnt;
   logic                  o_inst_rvalid;
   logic [DATA_WIDTH-1:0] o_inst_rdata;
   // data requester
   logic                  i_data_req;
   logic                  i_data_we;
   logic [ADDR_WIDTH-1:0] i_data_addr;
   logic [DATA_WIDTH-1:0] i_data_wdata;
   logic                  o_data_gnt;
   logic                  o_data_rvalid;
   logic [DATA_WIDTH-1:0] o_data_rdata;
   // SRAM port
   logic                  o_mem_en;
   logic                  o_mem_we;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic [DATA_WIDTH-1:0] i_mem_rdata;

   modport slave (
      input  i_inst_req, i_inst_addr,
      input  i_data_req, i_data_we, i_data_addr, i_data_wdata,
      input  i_mem_rdata,
      output o_inst_gnt, o_inst_rvalid, o_inst_rdata,
      output o_data_gnt, o_data_rvalid, o_data_rdata,
      output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );

   modport master (
      output i_inst_req, i_inst_addr,
      output i_data_req, i_data_we, i_data_addr, i_data_wdata,
      output i_mem_rdata,
      input  o_inst_gnt, o_inst_rvalid, o_inst_rdata,
      input  o_data_gnt, o_data_rvalid, o_data_rdata,
      input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch requester and the data requester. Data has priority
// unless instruction has been denied STARVE_LIMIT consecutive requesting
// cycles. Read data returns one cycle after the grant and is steered to the
// requester recorded in the owner register.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : inst/data requests, grants, read responses, SRAM port
//   o_inst_stall_cnt, o_conflict_cnt : saturating performance counters,
//                    present only when MEM_ARB_PERF_CNT_EN is defined
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]          o_inst_stall_cnt,
   output logic [31:0]          o_conflict_cnt
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] STARVE_MAX = '1;
   localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   owner_e           owner_q, owner_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   logic             inst_gnt, data_gnt;
   logic             inst_rvalid, data_rvalid;

   // state registers: response owner and instruction starvation count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         owner_q    <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         owner_q    <= owner_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // grant decision, next starvation count and next response owner
   always_comb begin
      inst_gnt   = 1'b0;
      data_gnt   = 1'b0;
      starve_nxt = starve_cnt;
      owner_nxt  = OWN_NONE;

      if (bus.i_inst_req && (!bus.i_data_req || (starve_cnt >= STARVE_THR))) begin
         inst_gnt = 1'b1;
      end else if (bus.i_data_req) begin
         data_gnt = 1'b1;
      end

      if (inst_gnt) begin
         starve_nxt = '0;
      end else if (bus.i_inst_req && (starve_cnt != STARVE_MAX)) begin
         starve_nxt = starve_cnt + CNT_W'(1);
      end

      if (inst_gnt) begin
         owner_nxt = OWN_INST;
      end else if (data_gnt && !bus.i_data_we) begin
         owner_nxt = OWN_DATA;
      end
   end

   assign bus.o_inst_gnt  = inst_gnt;
   assign bus.o_data_gnt  = data_gnt;

   // SRAM port: driven by the granted requester, zero when idle
   assign bus.o_mem_en    = inst_gnt | data_gnt;
   assign bus.o_mem_we    = data_gnt & bus.i_data_we;
   assign bus.o_mem_addr  = inst_gnt ? bus.i_inst_addr :
                            data_gnt ? bus.i_data_addr : ADDR_WIDTH'(0);
   assign bus.o_mem_wdata = data_gnt ? bus.i_data_wdata : DATA_WIDTH'(0);

   // response steering: SRAM data appears one cycle after the read grant
   assign inst_rvalid       = (owner_q == OWN_INST);
   assign data_rvalid       = (owner_q == OWN_DATA);
   assign bus.o_inst_rvalid = inst_rvalid;
   assign bus.o_data_rvalid = data_rvalid;
   assign bus.o_inst_rdata  = inst_rvalid ? bus.i_mem_rdata : DATA_WIDTH'(0);
   assign bus.o_data_rdata  = data_rvalid ? bus.i_mem_rdata : DATA_WIDTH'(0);

`ifdef MEM_ARB_PERF_CNT_EN
   // saturating counts of instruction stall cycles and contended cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_inst_stall_cnt <= '0;
         o_conflict_cnt   <= '0;
      end else begin
         if (bus.i_inst_req && !inst_gnt && (o_inst_stall_cnt != '1)) begin
            o_inst_stall_cnt <= o_inst_stall_cnt + 32'd1;
         end
         if (bus.i_inst_req && bus.i_data_req && (o_conflict_cnt != '1)) begin
            o_conflict_cnt <= o_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Expected read
// responses are queued when a cycle is driven and compared on the next cycle.
module tb_mem_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;

   typedef struct {
      logic [1:0]    kind;   // 0 none, 1 inst, 2 data
      logic [DW-1:0] data;
   } resp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   m_stall;
   int   m_conf;

   resp_t         sb[$];
   logic [DW-1:0] sram     [0:(1<<AW)-1];
   bit            sram_wr  [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
   bit            ref_wr   [0:(1<<AW)-1];

   mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] inst_stall_cnt;
   logic [31:0] conflict_cnt;
`endif

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .bus              (bus)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .o_inst_stall_cnt (inst_stall_cnt),
      .o_conflict_cnt   (conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // power-up SRAM contents; 0x010 holds an instruction word
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return (a == 12'h010) ? 32'h0050_0093 : {20'hA5A5A, a};
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : init_word(a);
   endfunction

   // behavioural single-port SRAM, one-cycle read latency
   always @(posedge clk) begin
      if (bus.o_mem_en) begin
         if (bus.o_mem_we) begin
            sram[bus.o_mem_addr]    <= bus.o_mem_wdata;
            sram_wr[bus.o_mem_addr] <= 1'b1;
         end else begin
            bus.i_mem_rdata <= sram_wr[bus.o_mem_addr] ? sram[bus.o_mem_addr]
                                                       : init_word(bus.o_mem_addr);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.i_inst_req   = 1'b0;
      bus.i_inst_addr  = '0;
      bus.i_data_req   = 1'b0;
      bus.i_data_we    = 1'b0;
      bus.i_data_addr  = '0;
      bus.i_data_wdata = '0;
   endtask

   // assert reset for one edge with idle inputs; outstanding responses are dropped
   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      #1;
      chk("rst_inst_rvalid", 64'(bus.o_inst_rvalid), 64'd0);
      chk("rst_data_rvalid", 64'(bus.o_data_rvalid), 64'd0);
      chk("rst_inst_rdata",  64'(bus.o_inst_rdata),  64'd0);
      chk("rst_data_rdata",  64'(bus.o_data_rdata),  64'd0);
      chk("rst_gnts",        64'({bus.o_inst_gnt, bus.o_data_gnt}), 64'd0);
      chk("rst_mem_en",      64'(bus.o_mem_en),    64'd0);
      chk("rst_mem_addr",    64'(bus.o_mem_addr),  64'd0);
      chk("rst_mem_wdata",   64'(bus.o_mem_wdata), 64'd0);
      sb.delete();
      sb.push_back('{2'd0, '0});
      m_stall = 0;
      m_conf  = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // one cycle: drive, check grants/SRAM port/last cycle's response, queue expectation
   task automatic step(input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] wd, input logic eig, input logic edg);
      resp_t e;
      logic [AW-1:0] e_addr;
      bus.i_inst_req   = ir;
      bus.i_inst_addr  = ia;
      bus.i_data_req   = dr;
      bus.i_data_we    = dw;
      bus.i_data_addr  = da;
      bus.i_data_wdata = wd;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_underflow", 64'd1, 64'd0);
         e = '{2'd0, '0};
      end else begin
         e = sb.pop_front();
      end
      chk("inst_rvalid", 64'(bus.o_inst_rvalid), 64'(e.kind == 2'd1));
      chk("inst_rdata",  64'(bus.o_inst_rdata),  64'((e.kind == 2'd1) ? e.data : '0));
      chk("data_rvalid", 64'(bus.o_data_rvalid), 64'(e.kind == 2'd2));
      chk("data_rdata",  64'(bus.o_data_rdata),  64'((e.kind == 2'd2) ? e.data : '0));
      e_addr = eig ? ia : (edg ? da : '0);
      chk("inst_gnt",  64'(bus.o_inst_gnt),  64'(eig));
      chk("data_gnt",  64'(bus.o_data_gnt),  64'(edg));
      chk("mem_en",    64'(bus.o_mem_en),    64'(eig | edg));
      chk("mem_we",    64'(bus.o_mem_we),    64'(edg & dw));
      chk("mem_addr",  64'(bus.o_mem_addr),  64'(e_addr));
      chk("mem_wdata", 64'(bus.o_mem_wdata), 64'(edg ? wd : '0));
      if (eig)             sb.push_back('{2'd1, ref_rd(ia)});
      else if (edg && !dw) sb.push_back('{2'd2, ref_rd(da)});
      else                 sb.push_back('{2'd0, '0});
      if (edg && dw) begin
         ref_mem[da] = wd;
         ref_wr[da]  = 1'b1;
      end
      if (ir && !eig) m_stall++;
      if (ir && dr)   m_conf++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

`ifdef MEM_ARB_PERF_CNT_EN
   task automatic chk_perf(input string tag);
      chk({tag, "_stall"},    64'(inst_stall_cnt), 64'(m_stall));
      chk({tag, "_conflict"}, 64'(conflict_cnt),   64'(m_conf));
   endtask
`endif

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_stall = 0;
      m_conf  = 0;
      drive_idle();
      rst_n = 1'b0;

      // reset state, then an idle cycle
      do_reset();
      idle_step();

      // instruction-only read of 0x010
      step(1'b1, 12'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      idle_step();

      // both requesting reads every cycle: data x4, then instruction, repeating
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 12'h010 + 12'(i), 1'b1, 1'b0, 12'h030 + 12'(i), '0,
              (i % 5) == 4, (i % 5) != 4);
      end
      idle_step();

      // write then read back
      step(1'b0, '0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b1);
      idle_step();
      chk("wr_rd_value", 64'(ref_rd(12'h020)), 64'h0000_0000_DEAD_BEEF);

      // alternating instruction and data read grants
      step(1'b1, 12'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b1);
      step(1'b1, 12'h011, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      idle_step();

      // reset in the cycle after an instruction grant drops the response
      step(1'b1, 12'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      do_reset();
      idle_step();
      idle_step();

      // three contended cycles after reset
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 12'h010, 1'b1, 1'b0, 12'h050 + 12'(i), '0, 1'b0, 1'b1);
      end
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_conf3", 64'(conflict_cnt), 64'd3);
      chk_perf("perf_a");
`endif
      idle_step();

      // data writes against instruction at the limit: fifth write is not performed
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 12'h010, 1'b1, 1'b1, 12'h040 + 12'(i), 32'h0000_1000 + 32'(i),
              i == 4, i != 4);
      end
      step(1'b0, '0, 1'b1, 1'b1, 12'h044, 32'h0000_2004, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 12'h043, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 12'h044, '0, 1'b0, 1'b1);
      idle_step();
`ifdef MEM_ARB_PERF_CNT_EN
      chk_perf("perf_b");
`endif

      // instruction requests with data idle keep going straight through
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      end
      idle_step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
